pwm_bank: RTL and testbench
===========================

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of PWM channels (legal range 1..8).
REQ-002 SHALL have parameter CW, default 8, meaning width of the period/duty counter (legal range 2..16).
REQ-003 SHALL have port clkin, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cs, input, 1, bus select for this block.
REQ-006 SHALL have port rdwr, input, 1, bus direction: 1 = write, 0 = read.
REQ-007 SHALL have port addr, input, 4, register address.
REQ-008 SHALL have port datain, input, 16, write data.
REQ-009 SHALL have port dataout, output, 16, read data.
REQ-010 SHALL have port pwm_out, output, NCH, per-channel PWM outputs.
REQ-011 SHALL have port prd_end, output, 1, one-cycle pulse at each period wrap.

Function
REQ-012 Register map SHALL be: 0 CTRL, 1 PERIOD, 2 PRESCALE, 3 COUNT (read-only), 4+i DUTY[i] for i < NCH; other addresses read 0 and ignore writes.
REQ-013 CTRL fields SHALL be: [NCH-1:0] channel enable EN, [8+NCH-1:8] polarity POL, [15] global RUN; unused bits read 0.
REQ-014 A write SHALL occur on the rising edge when cs=1 and rdwr=1; only the low CW bits are stored for PERIOD and DUTY.
REQ-015 dataout SHALL be combinational: the addressed register, zero-extended, when cs=1 and rdwr=0; otherwise 16'h0000.
REQ-016 Reads of PERIOD and DUTY SHALL return the last written value, not the active shadow value.
REQ-017 Prescaler: a 16-bit counter psc SHALL count 0..PRESCALE; tick=1 in the cycle psc==PRESCALE, after which psc returns to 0; PRESCALE=0 gives tick every cycle.
REQ-018 Main counter cnt (CW bits) SHALL advance by 1 on each tick while cnt < PERIOD_act, and load 0 on a tick when cnt == PERIOD_act (period length PERIOD_act+1 ticks).
REQ-019 On the wrap tick SHALL occur, in the same edge: PERIOD_act <= PERIOD, DUTY_act[i] <= DUTY[i] for all i, and prd_end asserted for exactly the following cycle.
REQ-020 pwm_out[i] SHALL be registered: (RUN & EN[i] & (cnt < DUTY_act[i])) XOR POL[i].
REQ-021 DUTY_act = 0 SHALL give constant inactive level; DUTY_act > PERIOD_act SHALL give constant active level (100%), no glitch at wrap.
REQ-022 When RUN=0: psc and cnt SHALL be held at 0, no prd_end pulses, shadows SHALL load directly from PERIOD/DUTY each cycle, pwm_out[i] = POL[i].
REQ-023 RUN 0->1 SHALL start with cnt=0, psc=0; the first tick occurs PRESCALE+1 cycles after the write edge.
REQ-024 Clearing EN[i] while running SHALL force pwm_out[i] to POL[i] on the next edge without disturbing other channels or cnt.
REQ-025 A PERIOD write that reduces the period below the current cnt SHALL NOT take effect before the next wrap; cnt continues to old PERIOD_act.
REQ-026 A bus write coinciding with the wrap tick SHALL be captured into the shadow in that same edge's next wrap, not the current one (shadow loads the pre-write register value).
REQ-027 COUNT read SHALL return cnt zero-extended.

Reset
REQ-028 On rst=1 at a rising edge: CTRL, PERIOD, PRESCALE, DUTY[*], their shadows, psc, cnt SHALL be 0; pwm_out SHALL be all 0; prd_end SHALL be 0.
REQ-029 rst SHALL override any simultaneous bus write; reset mid-period SHALL abort the period with no prd_end pulse.

Verification (NCH=4, CW=8)
REQ-030 Reset: assert rst 2 cycles with cs=1 write active -> all reads 0, pwm_out=4'b0000, prd_end=0.
REQ-031 Basic: PRESCALE=0, PERIOD=9, DUTY0=3, CTRL=16'h8001 -> pwm_out[0] high 3 of every 10 cycles, prd_end every 10 cycles.
REQ-032 Prescale/limits: PRESCALE=2, PERIOD=4, DUTY1=0, DUTY2=5, DUTY3=2, CTRL=16'h800E -> ch1 constant 0, ch2 constant 1, ch3 high 6 of every 15 cycles, prd_end period 15.
REQ-033 Shadowing: running PERIOD=9/DUTY0=3, write DUTY0=7 and PERIOD=3 mid-period -> current period unchanged; after next prd_end, 4-cycle period, 100% on ch0; DUTY0 read returns 7 immediately.
REQ-034 Polarity/enable: CTRL=16'h8F01 -> ch0 inverted waveform, ch1..3 constant 1; then CTRL=16'h0F01 -> all outputs 1, COUNT reads 0, no prd_end.
REQ-035 Unmapped/readback: write 16'hFFFF to addr 8 and 15 -> read 0; write PERIOD=16'h1234 -> read 16'h0034.

Source files
------------

// File: rtl/pwm_bank.sv
// pwm_bank: bank of NCH PWM channels sharing one prescaler and period counter.
// Ports: clkin/rst (sync, active high), cs/rdwr/addr/datain/dataout bus, pwm_out, prd_end.
module pwm_bank #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic           clkin,
  input  logic           rst,
  input  logic           cs,
  input  logic           rdwr,
  input  logic [3:0]     addr,
  input  logic [15:0]    datain,
  output logic [15:0]    dataout,
  output logic [NCH-1:0] pwm_out,
  output logic           prd_end
);

  localparam logic [3:0] A_CTRL = 4'd0;
  localparam logic [3:0] A_PER  = 4'd1;
  localparam logic [3:0] A_PSC  = 4'd2;
  localparam logic [3:0] A_CNT  = 4'd3;

  logic [NCH-1:0] r_en;
  logic [NCH-1:0] r_pol;
  logic           r_run;
  logic [CW-1:0]  r_period;
  logic [15:0]    r_prescale;
  logic [CW-1:0]  r_duty [NCH];

  logic [CW-1:0]  r_period_act;
  logic [CW-1:0]  r_duty_act [NCH];
  logic [15:0]    r_psc;
  logic [CW-1:0]  r_cnt;
  logic [NCH-1:0] r_pwm;
  logic           r_prd_end;

  logic           w_wr;
  logic           w_tick;
  logic           w_wrap;
  logic [15:0]    w_rdata;

  assign w_wr   = cs & rdwr;
  assign w_tick = r_run & (r_psc == r_prescale);
  assign w_wrap = w_tick & (r_cnt == r_period_act);

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_en       <= '0;
      r_pol      <= '0;
      r_run      <= 1'b0;
      r_period   <= '0;
      r_prescale <= '0;
    end else if (w_wr) begin
      if (addr == A_CTRL) begin
        r_en  <= datain[NCH-1:0];
        r_pol <= datain[8 +: NCH];
        r_run <= datain[15];
      end
      if (addr == A_PER)
        r_period <= datain[CW-1:0];
      if (addr == A_PSC)
        r_prescale <= datain;
    end
  end

  always_ff @(posedge clkin) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst)
        r_duty[i] <= '0;
      else if (w_wr && addr == 4'(i + 4))
        r_duty[i] <= datain[CW-1:0];
    end
  end

  // Shadows follow the bus registers while stopped, and only
  // reload at the wrap tick while running. Non-blocking reads
  // mean a coinciding bus write lands in the next period.
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_psc        <= '0;
      r_cnt        <= '0;
      r_prd_end    <= 1'b0;
      r_period_act <= '0;
      for (int i = 0; i < NCH; i++)
        r_duty_act[i] <= '0;
    end else if (!r_run) begin
      r_psc        <= '0;
      r_cnt        <= '0;
      r_prd_end    <= 1'b0;
      r_period_act <= r_period;
      for (int i = 0; i < NCH; i++)
        r_duty_act[i] <= r_duty[i];
    end else begin
      r_prd_end <= w_wrap;
      if (w_tick)
        r_psc <= '0;
      else
        r_psc <= r_psc + 16'd1;
      if (w_wrap) begin
        r_cnt        <= '0;
        r_period_act <= r_period;
        for (int i = 0; i < NCH; i++)
          r_duty_act[i] <= r_duty[i];
      end else if (w_tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        r_pwm[i] <= (r_run & r_en[i] & (r_cnt < r_duty_act[i])) ^ r_pol[i];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (addr)
      A_CTRL: begin
        w_rdata[NCH-1:0]  = r_en;
        w_rdata[8 +: NCH] = r_pol;
        w_rdata[15]       = r_run;
      end
      A_PER: w_rdata[CW-1:0] = r_period;
      A_PSC: w_rdata = r_prescale;
      A_CNT: w_rdata[CW-1:0] = r_cnt;
      default: begin
        for (int i = 0; i < NCH; i++)
          if (addr == 4'(i + 4))
            w_rdata[CW-1:0] = r_duty[i];
      end
    endcase
  end

  assign dataout = (cs & ~rdwr) ? w_rdata : 16'h0000;
  assign pwm_out = r_pwm;
  assign prd_end = r_prd_end;

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: self-checking bench for pwm_bank (NCH=4, CW=8).
// Table vectors, directed waveform sequences and random bus traffic vs a model.
module tb_pwm_bank;

  logic        clkin = 1'b0;
  logic        rst   = 1'b0;
  logic        cs    = 1'b0;
  logic        rdwr  = 1'b0;
  logic [3:0]  addr  = '0;
  logic [15:0] datain = '0;
  logic [15:0] dataout;
  logic [3:0]  pwm_out;
  logic        prd_end;

  always #5 clkin = ~clkin;

  pwm_bank #(.NCH(4), .CW(8)) dut (
    .clkin  (clkin),
    .rst    (rst),
    .cs     (cs),
    .rdwr   (rdwr),
    .addr   (addr),
    .datain (datain),
    .dataout(dataout),
    .pwm_out(pwm_out),
    .prd_end(prd_end)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: bus-visible registers kept as an address map,
  // the running period tracked as tick position within the period.
  logic [15:0] m_reg [16];
  int          m_per_act;
  int          m_duty_act [4];
  int          m_psc;
  int          m_cnt;
  logic [3:0]  m_pwm;
  logic        m_prd;

  task automatic model_reset();
    for (int a = 0; a < 16; a++) m_reg[a] = '0;
    for (int i = 0; i < 4; i++) m_duty_act[i] = 0;
    m_per_act = 0; m_psc = 0; m_cnt = 0;
    m_pwm = '0; m_prd = 1'b0;
  endtask

  task automatic model_edge();
    logic run;
    logic [3:0] en, pol;
    if (rst) begin
      model_reset();
      return;
    end
    run = m_reg[0][15];
    en  = m_reg[0][3:0];
    pol = m_reg[0][11:8];
    for (int i = 0; i < 4; i++)
      m_pwm[i] = (run && en[i] && (m_cnt < m_duty_act[i])) ^ pol[i];
    if (!run) begin
      m_psc = 0; m_cnt = 0; m_prd = 1'b0;
      m_per_act = m_reg[1];
      for (int i = 0; i < 4; i++) m_duty_act[i] = m_reg[4+i];
    end else if (m_psc == int'(m_reg[2])) begin
      m_psc = 0;
      m_prd = (m_cnt == m_per_act);
      if (m_prd) begin
        m_cnt = 0;
        m_per_act = m_reg[1];
        for (int i = 0; i < 4; i++) m_duty_act[i] = m_reg[4+i];
      end else begin
        m_cnt++;
      end
    end else begin
      m_psc = (m_psc + 1) % 65536;
      m_prd = 1'b0;
    end
    if (cs && rdwr) begin
      case (addr)
        4'd0: m_reg[0] = datain & 16'h8F0F;
        4'd1: m_reg[1] = datain & 16'h00FF;
        4'd2: m_reg[2] = datain;
        4'd4, 4'd5, 4'd6, 4'd7: m_reg[addr] = datain & 16'h00FF;
        default: ;
      endcase
    end
  endtask

  function automatic logic [15:0] exp_read();
    if (!(cs && !rdwr)) return 16'h0000;
    if (addr == 4'd3) return 16'(m_cnt);
    return m_reg[addr];
  endfunction

  task automatic step();
    @(posedge clkin);
    model_edge();
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    chk("prd_end", 32'(prd_end), 32'(m_prd));
    chk("dataout", 32'(dataout), 32'(exp_read()));
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cs = 1'b1; rdwr = 1'b1; addr = a; datain = d;
    step();
    cs = 1'b0; rdwr = 1'b0; datain = '0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e, input string nm);
    cs = 1'b1; rdwr = 1'b0; addr = a;
    step();
    chk(nm, 32'(dataout), 32'(e));
    cs = 1'b0;
  endtask

  int c_hi [4];
  int c_prd;

  task automatic run_count(input int n);
    for (int i = 0; i < 4; i++) c_hi[i] = 0;
    c_prd = 0;
    for (int k = 0; k < n; k++) begin
      step();
      for (int i = 0; i < 4; i++) if (pwm_out[i] === 1'b1) c_hi[i]++;
      if (prd_end === 1'b1) c_prd++;
    end
  endtask

  task automatic wait_prd(input int mx, output int n);
    n = -1;
    for (int k = 1; k <= mx; k++) begin
      step();
      if (prd_end === 1'b1) begin
        n = k;
        break;
      end
    end
    chk("prd_wait_timeout", 32'(n > 0), 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  a;
    logic [15:0] d;
    logic [15:0] e;
  } vec_t;

  vec_t tbl [14];
  int   n;

  initial begin
    model_reset();

    tbl[0]  = '{1'b1, 4'd8,  16'hFFFF, 16'h0000};
    tbl[1]  = '{1'b1, 4'd15, 16'hFFFF, 16'h0000};
    tbl[2]  = '{1'b0, 4'd8,  16'h0000, 16'h0000};
    tbl[3]  = '{1'b0, 4'd15, 16'h0000, 16'h0000};
    tbl[4]  = '{1'b1, 4'd1,  16'h1234, 16'h0000};
    tbl[5]  = '{1'b0, 4'd1,  16'h0000, 16'h0034};
    tbl[6]  = '{1'b1, 4'd2,  16'hABCD, 16'h0000};
    tbl[7]  = '{1'b0, 4'd2,  16'h0000, 16'hABCD};
    tbl[8]  = '{1'b1, 4'd0,  16'h7F7F, 16'h0000};
    tbl[9]  = '{1'b0, 4'd0,  16'h0000, 16'h0F0F};
    tbl[10] = '{1'b1, 4'd4,  16'h01FF, 16'h0000};
    tbl[11] = '{1'b0, 4'd4,  16'h0000, 16'h00FF};
    tbl[12] = '{1'b0, 4'd3,  16'h0000, 16'h0000};
    tbl[13] = '{1'b1, 4'd0,  16'h0000, 16'h0000};

    // reset with a write pending
    rst = 1'b1; cs = 1'b1; rdwr = 1'b1; addr = 4'd0; datain = 16'hFFFF;
    step();
    step();
    rst = 1'b0; cs = 1'b0; rdwr = 1'b0; datain = '0;
    chk("rst_pwm", 32'(pwm_out), 32'h0);
    chk("rst_prd", 32'(prd_end), 32'h0);
    for (int a = 0; a < 16; a++) rd(4'(a), 16'h0000, "rst_read");

    // readback / unmapped table
    foreach (tbl[i]) begin
      if (tbl[i].wr) wr(tbl[i].a, tbl[i].d);
      else rd(tbl[i].a, tbl[i].e, "tbl_read");
    end

    // basic waveform
    wr(4'd2, 16'd0);
    wr(4'd1, 16'd9);
    wr(4'd4, 16'd3);
    wr(4'd0, 16'h8001);
    run_count(12);
    run_count(30);
    chk("basic_hi0", c_hi[0], 9);
    chk("basic_hi1", c_hi[1], 0);
    chk("basic_prd", c_prd, 3);

    // reset mid-period
    wait_prd(20, n);
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_pwm", 32'(pwm_out), 32'h0);
    chk("midrst_prd", 32'(prd_end), 32'h0);
    run_count(12);
    chk("midrst_noprd", c_prd, 0);

    // prescale and duty limits
    wr(4'd2, 16'd2);
    wr(4'd1, 16'd4);
    wr(4'd5, 16'd0);
    wr(4'd6, 16'd5);
    wr(4'd7, 16'd2);
    wr(4'd0, 16'h800E);
    run_count(20);
    run_count(45);
    chk("psc_hi0", c_hi[0], 0);
    chk("psc_hi1", c_hi[1], 0);
    chk("psc_hi2", c_hi[2], 45);
    chk("psc_hi3", c_hi[3], 18);
    chk("psc_prd", c_prd, 3);

    // shadowing of mid-period writes
    wr(4'd0, 16'h0000);
    wr(4'd2, 16'd0);
    wr(4'd1, 16'd9);
    wr(4'd4, 16'd3);
    wr(4'd0, 16'h8001);
    wait_prd(30, n);
    for (int k = 0; k < 3; k++) step();
    wr(4'd4, 16'd7);
    rd(4'd4, 16'd7, "shadow_duty_rd");
    wr(4'd1, 16'd3);
    wait_prd(20, n);
    chk("shadow_old_len", n + 6, 10);
    wait_prd(20, n);
    chk("shadow_new_len", n, 4);
    step();
    run_count(8);
    chk("shadow_hi0", c_hi[0], 8);
    chk("shadow_prd", c_prd, 2);

    // polarity and enable
    wr(4'd0, 16'h0000);
    wr(4'd1, 16'd9);
    wr(4'd4, 16'd3);
    wr(4'd0, 16'h8F01);
    run_count(15);
    run_count(20);
    chk("pol_hi0", c_hi[0], 14);
    chk("pol_hi1", c_hi[1], 20);
    chk("pol_hi3", c_hi[3], 20);
    wr(4'd0, 16'h0F01);
    step();
    step();
    chk("stop_pwm", 32'(pwm_out), 32'hF);
    rd(4'd3, 16'h0000, "stop_count");
    run_count(10);
    chk("stop_prd", c_prd, 0);
    chk("stop_hi0", c_hi[0], 10);

    // random traffic against the model
    for (int it = 0; it < 600; it++) begin
      int sel;
      logic [3:0] a;
      sel = $urandom_range(0, 99);
      a = 4'($urandom_range(0, 15));
      if (sel < 2) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else if (sel < 35) begin
        case (a)
          4'd0: wr(a, 16'($urandom) | (($urandom_range(0, 4) != 0) ? 16'h8000 : 16'h0));
          4'd1: wr(a, 16'($urandom_range(0, 15)));
          4'd2: wr(a, 16'($urandom_range(0, 3)));
          default: wr(a, 16'($urandom_range(0, 17)));
        endcase
      end else if (sel < 55) begin
        cs = 1'b1; rdwr = 1'b0; addr = a;
        step();
        cs = 1'b0;
      end else begin
        for (int k = 0; k < int'($urandom_range(1, 6)); k++) step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
